sync_fifo: RTL and testbench

//   Single-clock synchronous FIFO buffering DATA_WIDTH-bit words, DATA_DEPTH entries deep.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_if.sv | 39 +++
 rtl/sync_fifo_ram.sv | 41 ++++
 rtl/sync_fifo.sv | 103 ++++++++++
 tb/tb_sync_fifo.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and an
// address-width helper used by the RTL and by benches.
package sync_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DATA_DEPTH = 4;

   // Number of bits needed to index 'value' entries (value >= 1).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) begin
            result = result + 1;
         end
      end
      return result;
   endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the synchronous FIFO.
//
// Handshake: a write is accepted on a rising edge where wren=1 and full=0;
// a read is accepted on a rising edge where rden=1 and empty=0. full/empty
// act as the inverse of "ready"; a request made while its flag is set is
// dropped, not held. Read data appears on dout after the accepting edge and
// stays there until the next accepted read.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] din;
   logic                  wren;
   logic                  full;
   logic [DATA_WIDTH-1:0] dout;
   logic                  rden;
   logic                  empty;

   // Producer/consumer side: drives requests and write data.
   modport master (
      output din,
      output wren,
      output rden,
      input  full,
      input  dout,
      input  empty
   );

   // FIFO side: consumes requests, drives status and read data.
   modport slave (
      input  din,
      input  wren,
      input  rden,
      output full,
      output dout,
      output empty
   );

endinterface : sync_fifo_if

// File: rtl/sync_fifo_ram.sv
// DATA_DEPTH x DATA_WIDTH storage with one write port and one registered
// read port. Storage is never cleared; only the read register resets.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DATA_DEPTH = DEF_DATA_DEPTH,
   localparam int ADDR_W     = clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Write port: store the word at the write address when enabled.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port: capture the addressed word; hold it when no read is enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : sync_fifo_ram

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO. Pointers carry one extra wrap bit so full
// and empty are told apart without a separate counter.
// Optional feature: define SYNC_FIFO_LEVEL_EN to add the registered
// occupancy output 'level'.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DATA_DEPTH = DEF_DATA_DEPTH,
   localparam int ADDR_W     = clog2(DATA_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   sync_fifo_if.slave    bus
`ifdef SYNC_FIFO_LEVEL_EN
   ,
   output logic [ADDR_W:0] level
`endif
);

   logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] rdata;

   // Acceptance uses the registered flags, i.e. the state before the edge.
   always_comb begin
      wr_acc = bus.wren & ~full_q;
      rd_acc = bus.rden & ~empty_q;
   end

   // Next pointers and flags; pointers wrap naturally at 2^(ADDR_W+1).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
   end

   // Pointer and flag registers; reset discards all contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

`ifdef SYNC_FIFO_LEVEL_EN
   logic [ADDR_W:0] level_q, level_d;

   // Occupancy follows the next pointers so it moves on the same edge.
   always_comb begin
      level_d = wr_ptr_d - rd_ptr_d;
   end

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;
`endif

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (bus.din),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (rdata)
   );

   assign bus.dout  = rdata;
   assign bus.empty = empty_q;
   assign bus.full  = full_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (8-bit words, 4 entries).
module tb_sync_fifo;
   import sync_fifo_pkg::*;

   localparam int W = DEF_DATA_WIDTH;
   localparam int D = DEF_DATA_DEPTH;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   sync_fifo_if #(.DATA_WIDTH(W)) bus ();

`ifdef SYNC_FIFO_LEVEL_EN
   logic [2:0] level;
`endif

   sync_fifo #(
      .DATA_WIDTH (W),
      .DATA_DEPTH (D)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus)
`ifdef SYNC_FIFO_LEVEL_EN
      ,
      .level (level)
`endif
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   int           model_cnt;
   logic [W-1:0] model_dout;
   logic [W-1:0] next_din;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_level(input string tag, input int exp);
`ifdef SYNC_FIFO_LEVEL_EN
      check(tag, 32'(level), 32'(exp));
`else
      if (exp < 0) $display("unused level %s", tag);
`endif
   endtask

   // Driver: one write attempt per cycle; the model decides acceptance.
   task automatic burst_write(input int n);
      for (int i = 0; i < n; i++) begin
         bus.wren = 1'b1;
         bus.rden = 1'b0;
         bus.din  = next_din;
         tick();
         if (model_cnt < D) begin
            exp_q.push_back(next_din);
            model_cnt++;
            next_din++;
         end
         check("rnd_w_full", 32'(bus.full), 32'(model_cnt == D));
         check("rnd_w_empty", 32'(bus.empty), 32'(model_cnt == 0));
         check("rnd_w_dout", 32'(bus.dout), 32'(model_dout));
         check_level("rnd_w_level", model_cnt);
      end
      bus.wren = 1'b0;
   endtask

   // Driver: one read attempt per cycle; popped words are compared in order.
   task automatic burst_read(input int n);
      for (int i = 0; i < n; i++) begin
         bus.wren = 1'b0;
         bus.rden = 1'b1;
         tick();
         if (model_cnt > 0) begin
            model_dout = exp_q.pop_front();
            model_cnt--;
         end
         check("rnd_r_dout", 32'(bus.dout), 32'(model_dout));
         check("rnd_r_full", 32'(bus.full), 32'(model_cnt == D));
         check("rnd_r_empty", 32'(bus.empty), 32'(model_cnt == 0));
         check_level("rnd_r_level", model_cnt);
      end
      bus.rden = 1'b0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      bus.wren = 1'b0;
      bus.rden = 1'b0;
      bus.din  = '0;
      tick();
      tick();
      rst = 1'b0;

      // 1. reset state, then reads against empty
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'h00);
      check_level("rst_level", 0);
      bus.rden = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_rd_empty", 32'(bus.empty), 32'd1);
         check("idle_rd_full", 32'(bus.full), 32'd0);
         check("idle_rd_dout", 32'(bus.dout), 32'h00);
      end
      bus.rden = 1'b0;

      // 2. five writes, fifth rejected by full
      bus.wren = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.din = (i < 4) ? W'(i) : W'(4);
         tick();
         check("fill_full", 32'(bus.full), 32'(i >= 3));
         check("fill_empty", 32'(bus.empty), 32'd0);
         check_level("fill_level", (i < 4) ? i + 1 : 4);
      end
      bus.wren = 1'b0;

      // 3. drain four words
      bus.rden = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_dout", 32'(bus.dout), 32'(i));
         check("drain_full", 32'(bus.full), 32'd0);
         check("drain_empty", 32'(bus.empty), 32'(i == 3));
      end
      bus.rden = 1'b0;
      tick();
      check("hold_dout", 32'(bus.dout), 32'h03);

      // 4. two stored, then simultaneous read/write across pointer wrap
      bus.wren = 1'b1;
      bus.din  = 8'h04;
      tick();
      bus.din  = 8'h05;
      tick();
      check_level("pre_rw_level", 2);
      bus.rden = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.din = W'(6 + i);
         tick();
         check("rw_dout", 32'(bus.dout), 32'(4 + i));
         check("rw_empty", 32'(bus.empty), 32'd0);
         check("rw_full", 32'(bus.full), 32'd0);
         check_level("rw_level", 2);
      end
      bus.wren = 1'b0;
      tick();
      check("rw_tail0", 32'(bus.dout), 32'h0a);
      tick();
      check("rw_tail1", 32'(bus.dout), 32'h0b);
      check("rw_tail_empty", 32'(bus.empty), 32'd1);
      bus.rden = 1'b0;

      // 5. reset in the middle of a burst
      bus.wren = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.din = W'(12 + i);
         tick();
      end
      check_level("pre_rst_level", 3);
      rst     = 1'b1;
      bus.din = 8'h0f;
      tick();
      rst      = 1'b0;
      bus.wren = 1'b0;
      check("mid_rst_empty", 32'(bus.empty), 32'd1);
      check("mid_rst_full", 32'(bus.full), 32'd0);
      check("mid_rst_dout", 32'(bus.dout), 32'h00);
      check_level("mid_rst_level", 0);
      bus.wren = 1'b1;
      bus.din  = 8'h20;
      tick();
      bus.din  = 8'h21;
      tick();
      bus.wren = 1'b0;
      bus.rden = 1'b1;
      tick();
      check("post_rst_dout0", 32'(bus.dout), 32'h20);
      tick();
      check("post_rst_dout1", 32'(bus.dout), 32'h21);
      check("post_rst_empty", 32'(bus.empty), 32'd1);
      bus.rden = 1'b0;

      // 6. bursts against the scoreboard queue
      model_cnt  = 0;
      model_dout = 8'h21;
      next_din   = W'($urandom_range(8'h40, 8'h80));
      burst_write(5);
      burst_read(3);
      burst_write(7);
      burst_read(13);
      burst_write(3);
      burst_read(7);
      burst_write(9);
      burst_read(9);
      burst_write(1);
      burst_read(4);
      burst_read(7);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sync_fifo
